// File: rtl/run_ctrl.sv
// Run controller: turns operator start/stop requests into start pulses for the
// pulse distributor, honouring step/instruction/auto modes and a minimum pulse gap.
module run_ctrl #(
  parameter int START_GAP = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        btn_start_from_io,
  input  logic        btn_stop_from_io,
  input  logic [1:0]  mode_from_io,
  input  logic        waiting_from_pulse,
  input  logic        operate_pulse_from_pulse,
  input  logic        halt_from_op,
  output logic        start_pulse_to_pulse,
  output logic        running_to_io,
  output logic [15:0] start_count_to_io
);

  localparam logic [1:0] MODE_INSTR = 2'b01;
  localparam logic [1:0] MODE_AUTO  = 2'b10;
  localparam logic [7:0] GAP_LOAD   = 8'(START_GAP - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    GAP   = 2'b10
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  mode_q, mode_nxt;
  logic        stop_pending, stop_nxt;
  logic [7:0]  gap_cnt, gap_nxt;
  logic [15:0] count_nxt;
  logic        stop_set;

  // Any stop source seen while running; operate_pulse only ends a run in instruction mode.
  assign stop_set = btn_stop_from_io | halt_from_op |
                    (operate_pulse_from_pulse & (mode_q == MODE_INSTR));

  assign running_to_io = (state != IDLE);

  always_comb begin
    state_nxt            = state;
    mode_nxt             = mode_q;
    stop_nxt             = stop_pending;
    gap_nxt              = gap_cnt;
    count_nxt            = start_count_to_io;
    start_pulse_to_pulse = 1'b0;
    case (state)
      IDLE: begin
        if (btn_start_from_io && !btn_stop_from_io) begin
          state_nxt = ISSUE;
          mode_nxt  = mode_from_io;
          stop_nxt  = 1'b0;
          count_nxt = 16'd0;
        end
      end
      ISSUE: begin
        stop_nxt = stop_pending | stop_set;
        if (stop_pending || stop_set) begin
          state_nxt = IDLE;
        end else if (waiting_from_pulse) begin
          start_pulse_to_pulse = 1'b1;
          count_nxt            = start_count_to_io + 16'd1;
          if ((mode_q == MODE_INSTR) || (mode_q == MODE_AUTO)) begin
            state_nxt = GAP;
            gap_nxt   = GAP_LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      GAP: begin
        // A stop is only recorded here; ISSUE acts on it so the gap always completes.
        stop_nxt = stop_pending | stop_set;
        if (gap_cnt == 8'd0) begin
          state_nxt = ISSUE;
        end else begin
          gap_nxt = gap_cnt - 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state             <= IDLE;
      mode_q            <= 2'b00;
      stop_pending      <= 1'b0;
      gap_cnt           <= 8'd0;
      start_count_to_io <= 16'd0;
    end else begin
      state             <= state_nxt;
      mode_q            <= mode_nxt;
      stop_pending      <= stop_nxt;
      gap_cnt           <= gap_nxt;
      start_count_to_io <= count_nxt;
    end
  end

endmodule
